serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 cin  input  1  carry-in; captured on the accepted start edge.
REQ-008 sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH.
REQ-009 cout  output  1  registered carry-out of the WIDTH-bit addition.
REQ-010 busy  output  1  high while a bit-serial addition is in progress.
REQ-011 done  output  1  one-cycle pulse; sum/cout valid and newly updated.

Function
REQ-012 The block SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at a rising edge SHALL:
- load a and b into internal shift registers;
- load cin into the carry flip-flop;
- clear the bit counter;
- enter RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE with all outputs held.
REQ-015 Each RUN edge SHALL compute one full-adder bit from the operand LSBs and the carry flip-flop:
- s = a0^b0^c;
- c' = a0b0 | c(a0^b0).
REQ-016 Each RUN edge SHALL right-shift both operand registers by one bit.
REQ-017 Each RUN edge SHALL shift s into the MSB of the partial-sum register.
REQ-018 Each RUN edge SHALL store c' in the carry flip-flop and increment the counter.
REQ-019 On the WIDTH-th RUN edge (counter = WIDTH-1), the block SHALL:
- write the completed partial sum to sum;
- write c' to cout;
- enter DONE.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-021 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; both SHALL be registered, state-decoded and glitch-free.
REQ-022 Latency: with start accepted at edge E, done SHALL be high in the cycle after edge E+WIDTH; one operation occupies WIDTH+2 cycles.
REQ-023 start SHALL be ignored in RUN and DONE; there is no queueing, and the in-flight operands SHALL be unaffected.
REQ-024 start held high continuously SHALL launch a new operation on the first IDLE edge after each DONE.
REQ-025 Changes on a, b and cin after the accepted start edge SHALL NOT affect the result.
REQ-026 sum and cout SHALL hold their last value until the next DONE entry; they SHALL NOT show partial results during RUN.
REQ-027 Overflow SHALL wrap: sum = (a+b+cin) mod 2^WIDTH, and cout = 1 exactly when a+b+cin >= 2^WIDTH.

Reset
REQ-028 Assertion of rst SHALL immediately, without a clock, force:
- state to IDLE;
- sum = 0, cout = 0, busy = 0, done = 0;
- the carry flip-flop, counter and shift registers to 0.
REQ-029 rst asserted mid-RUN SHALL abort the operation, with no done pulse and no sum/cout update.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-031 a=0x00, b=0x00, cin=0, start pulse -> done after 8 RUN cycles, sum=0x00, cout=0; busy high exactly 8 cycles.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-033 a=0x5A, b=0x33, cin=0 -> sum=0x8D, cout=0. Change a and b on every cycle of RUN -> result unchanged.
REQ-034 Second start pulse at RUN cycle 3 with a=0x11, b=0x22 -> ignored. First result is delivered, then IDLE, with no second done.
REQ-035 rst pulse at RUN cycle 4 -> busy=0 and sum/cout=0 immediately, no done pulse; next start with 0x0F+0x01+0 -> sum=0x10, cout=0.
REQ-036 Random a, b, cin for 1000 operations with start tied high -> every done matches a+b+cin, with done spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, WIDTH RUN cycles per operation.
// sum/cout update only on DONE entry; busy/done are registered decodes of the next state.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             s_bit, c_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        s_bit   = a_q[0] ^ b_q[0] ^ carry_q;
        c_next  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                psum_d  = {s_bit, psum_q[WIDTH-1:1]};
                carry_d = c_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = psum_d;
                    cout_d  = c_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Decoding the next state keeps busy/done registered yet aligned with the state.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): hand-computed vectors, abort and back-to-back checks.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;

    int checks;
    int errors;
    logic [7:0] last_sum;
    logic       last_cout;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches one operation from IDLE at a negedge and follows it to done.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input logic [7:0] es, input logic ec, input bit scramble,
                         input bit inject, input string tag);
        int cyc;
        int nbusy;
        start = 1'b1; a = av; b = bv; cin = cv;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        nbusy = 0;
        while (!done && cyc < 20) begin
            if (busy) nbusy++;
            if (cyc == 4) begin
                check({tag, "_sum_hold"}, {24'd0, sum}, {24'd0, last_sum});
                check({tag, "_cout_hold"}, {31'd0, cout}, {31'd0, last_cout});
            end
            if (scramble) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            if (inject) begin
                if (cyc == 2) begin
                    start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_latency"}, cyc, 32'd8);
        check({tag, "_busy_cycles"}, nbusy, 32'd8);
        check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        last_sum = es;
        last_cout = ec;
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [8:0] exp9;
        bit seen_done;
        bit seen_busy;
        int cyc;

        checks = 0;
        errors = 0;
        last_sum = 8'h00;
        last_cout = 1'b0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);

        // Directed vectors
        do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "zero");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "ff_p_01");
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "ff_p_ff_c");
        do_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b0, "scramble");

        // Start during RUN is ignored; no second done afterwards
        do_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b1, "ignore_start");
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        check("no_second_done", {31'd0, seen_done}, 32'd0);
        check("no_second_busy", {31'd0, seen_busy}, 32'd0);
        check("ignore_sum_kept", {24'd0, sum}, 32'h47);

        // Reset mid-RUN aborts immediately
        start = 1'b1; a = 8'h77; b = 8'h11; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        last_sum = 8'h00;
        last_cout = 1'b0;
        do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, "after_rst");

        // Start tied high: back-to-back random operations every 10 cycles
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            exp9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done && cyc < 30);
            check("rand_done", {31'd0, done}, 32'd1);
            if (i > 0) check("rand_spacing", cyc, 32'd10);
            check("rand_sum", {24'd0, sum}, {24'd0, exp9[7:0]});
            check("rand_cout", {31'd0, cout}, {31'd0, exp9[8]});
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
